// File: rtl/dma_sched.sv
// Two-requester DMA descriptor scheduler: per-requester FIFOs, round-robin issue
// to one shared DMA engine with parameter hold, completion pulses and timeout.
module dma_sched #(
  parameter int          DEPTH   = 4,
  parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
  input  logic         hclk,
  input  logic         hresetn,
  input  logic         i_r0_valid,
  output logic         o_r0_ready,
  input  logic [111:0] i_r0_desc,
  output logic         o_r0_done,
  output logic         o_r0_err,
  input  logic         i_r1_valid,
  output logic         o_r1_ready,
  input  logic [111:0] i_r1_desc,
  output logic         o_r1_done,
  output logic         o_r1_err,
  output logic         o_dma_req,
  output logic [31:0]  o_src_addr,
  output logic [31:0]  o_dst_addr,
  output logic [15:0]  o_poly_deg,
  output logic         o_src_rev,
  output logic         o_dst_rev,
  output logic [14:0]  o_addr_inc,
  output logic [14:0]  o_burst_size,
  input  logic         i_dma_done,
  input  logic         i_clr_err,
  output logic         o_busy,
  output logic [31:0]  o_status
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, WAIT = 2'd2, GAP = 2'd3} state_t;
  localparam int         AW      = $clog2(DEPTH);
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  state_t        state_r, state_nxt_s;
  logic          owner_r, owner_nxt_s, gnt_s, any_s, load_s;
  logic          err_r, err_nxt_s, tmo_hit_r, tmo_hit_nxt_s, sticky_r;
  logic [15:0]   tmo_r, count_r;
  logic [1:0]    valid_s, full_s, push_s, pop_s, done_r, derr_r;
  logic [111:0]  din_s [2];
  logic [111:0]  mem_r [2][DEPTH];
  logic [AW-1:0] wptr_r [2];
  logic [AW-1:0] rptr_r [2];
  logic [3:0]    cnt_r [2];
  logic [111:0]  head_s;

  assign valid_s  = {i_r1_valid, i_r0_valid};
  assign din_s[0] = i_r0_desc;
  assign din_s[1] = i_r1_desc;

  // Push qualification: ready reflects registered occupancy only, no bypass on pop
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      full_s[i] = (cnt_r[i] == DEPTH_C);
      push_s[i] = valid_s[i] && !full_s[i];
    end
  end

  // Descriptor storage
  always_ff @(posedge hclk) begin
    for (int i = 0; i < 2; i++) begin
      if (push_s[i]) begin
        mem_r[i][wptr_r[i]] <= din_s[i];
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      for (int i = 0; i < 2; i++) begin
        wptr_r[i] <= '0;
        rptr_r[i] <= '0;
        cnt_r[i]  <= 4'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push_s[i]) wptr_r[i] <= wptr_r[i] + AW'(1'b1);
        if (pop_s[i])  rptr_r[i] <= rptr_r[i] + AW'(1'b1);
        cnt_r[i] <= cnt_r[i] + {3'd0, push_s[i]} - {3'd0, pop_s[i]};
      end
    end
  end

  // r1 wins only when r0 is empty or r0 was granted last
  assign any_s  = (cnt_r[0] != 4'd0) || (cnt_r[1] != 4'd0);
  assign gnt_s  = (cnt_r[1] != 4'd0) && ((cnt_r[0] == 4'd0) || !owner_r);
  assign head_s = mem_r[gnt_s][rptr_r[gnt_s]];

  // Next-state and grant decode
  always_comb begin
    state_nxt_s   = state_r;
    owner_nxt_s   = owner_r;
    err_nxt_s     = err_r;
    tmo_hit_nxt_s = tmo_hit_r;
    pop_s         = 2'b00;
    load_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (any_s) begin
          pop_s         = gnt_s ? 2'b10 : 2'b01;
          load_s        = 1'b1;
          owner_nxt_s   = gnt_s;
          tmo_hit_nxt_s = 1'b0;
          if (head_s[14:4] == 11'd0) begin
            state_nxt_s = GAP;
            err_nxt_s   = 1'b1;
          end else begin
            state_nxt_s = LOAD;
            err_nxt_s   = 1'b0;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD: state_nxt_s = WAIT;
      WAIT: begin
        if (i_dma_done) begin
          state_nxt_s = GAP;
          err_nxt_s   = 1'b0;
        end else if (tmo_r == TIMEOUT) begin
          state_nxt_s   = GAP;
          err_nxt_s     = 1'b1;
          tmo_hit_nxt_s = 1'b1;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      GAP:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Control state, timeout counter, completion count and registered strobes
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_r   <= IDLE;
      owner_r   <= 1'b1;
      err_r     <= 1'b0;
      tmo_hit_r <= 1'b0;
      tmo_r     <= 16'd0;
      count_r   <= 16'd0;
      sticky_r  <= 1'b0;
      done_r    <= 2'b00;
      derr_r    <= 2'b00;
      o_dma_req <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      owner_r   <= owner_nxt_s;
      err_r     <= err_nxt_s;
      tmo_hit_r <= tmo_hit_nxt_s;
      o_dma_req <= (state_nxt_s == WAIT);
      o_busy    <= (state_nxt_s != IDLE);
      done_r[0] <= (state_nxt_s == GAP) && !owner_nxt_s;
      done_r[1] <= (state_nxt_s == GAP) && owner_nxt_s;
      derr_r[0] <= (state_nxt_s == GAP) && !owner_nxt_s && err_nxt_s;
      derr_r[1] <= (state_nxt_s == GAP) && owner_nxt_s && err_nxt_s;
      if (state_r == LOAD)      tmo_r <= 16'd0;
      else if (state_r == WAIT) tmo_r <= tmo_r + 16'd1;
      if (state_r == GAP) count_r <= count_r + 16'd1;
      if ((state_r == GAP) && tmo_hit_r) sticky_r <= 1'b1;
      else if (i_clr_err)                sticky_r <= 1'b0;
    end
  end

  // Issued descriptor fields, held from LOAD through GAP
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      o_src_addr   <= 32'd0;
      o_dst_addr   <= 32'd0;
      o_poly_deg   <= 16'd0;
      o_src_rev    <= 1'b0;
      o_dst_rev    <= 1'b0;
      o_addr_inc   <= 15'd0;
      o_burst_size <= 15'd0;
    end else if (load_s) begin
      o_src_addr   <= head_s[111:80];
      o_dst_addr   <= head_s[79:48];
      o_poly_deg   <= head_s[47:32];
      o_src_rev    <= head_s[31];
      o_dst_rev    <= head_s[30];
      o_addr_inc   <= head_s[29:15];
      o_burst_size <= head_s[14:0];
    end
  end

  assign o_r0_ready = !full_s[0];
  assign o_r1_ready = !full_s[1];
  assign o_r0_done  = done_r[0];
  assign o_r1_done  = done_r[1];
  assign o_r0_err   = derr_r[0];
  assign o_r1_err   = derr_r[1];
  assign o_status   = {count_r, cnt_r[0], cnt_r[1], 4'd0, sticky_r, owner_r, 2'(state_r)};

endmodule

// File: tb/tb_dma_sched.sv
// Self-checking bench for dma_sched: vector table for round-robin fill, a done-pulse
// scoreboard, and directed sequences for full FIFO, reject, timeout and reset.
module tb_dma_sched;

  logic hclk = 1'b0, hresetn = 1'b0;
  logic v0 = 1'b0, v1 = 1'b0, dma_done = 1'b0, clr_err = 1'b0;
  logic [111:0] d0 = '0, d1 = '0;

  logic r0_ready, r0_done, r0_err, r1_ready, r1_done, r1_err, dma_req, src_rev, dst_rev, busy;
  logic [31:0] src_addr, dst_addr, status;
  logic [15:0] poly_deg;
  logic [14:0] addr_inc, burst_size;

  logic t_r0_ready, t_r0_done, t_r0_err, t_r1_ready, t_r1_done, t_r1_err, t_dma_req;
  logic t_src_rev, t_dst_rev, t_busy;
  logic [31:0] t_src_addr, t_dst_addr, t_status;
  logic [15:0] t_poly_deg;
  logic [14:0] t_addr_inc, t_burst_size;

  always #5 hclk = ~hclk;

  dma_sched #(.DEPTH(4), .TIMEOUT(16'hFFFF)) dut (
    .hclk(hclk), .hresetn(hresetn),
    .i_r0_valid(v0), .o_r0_ready(r0_ready), .i_r0_desc(d0), .o_r0_done(r0_done), .o_r0_err(r0_err),
    .i_r1_valid(v1), .o_r1_ready(r1_ready), .i_r1_desc(d1), .o_r1_done(r1_done), .o_r1_err(r1_err),
    .o_dma_req(dma_req), .o_src_addr(src_addr), .o_dst_addr(dst_addr), .o_poly_deg(poly_deg),
    .o_src_rev(src_rev), .o_dst_rev(dst_rev), .o_addr_inc(addr_inc), .o_burst_size(burst_size),
    .i_dma_done(dma_done), .i_clr_err(clr_err), .o_busy(busy), .o_status(status));

  dma_sched #(.DEPTH(4), .TIMEOUT(16'd8)) dut_t (
    .hclk(hclk), .hresetn(hresetn),
    .i_r0_valid(v0), .o_r0_ready(t_r0_ready), .i_r0_desc(d0), .o_r0_done(t_r0_done), .o_r0_err(t_r0_err),
    .i_r1_valid(v1), .o_r1_ready(t_r1_ready), .i_r1_desc(d1), .o_r1_done(t_r1_done), .o_r1_err(t_r1_err),
    .o_dma_req(t_dma_req), .o_src_addr(t_src_addr), .o_dst_addr(t_dst_addr), .o_poly_deg(t_poly_deg),
    .o_src_rev(t_src_rev), .o_dst_rev(t_dst_rev), .o_addr_inc(t_addr_inc), .o_burst_size(t_burst_size),
    .i_dma_done(dma_done), .i_clr_err(clr_err), .o_busy(t_busy), .o_status(t_status));

  typedef struct {logic owner; logic err; logic [31:0] src;} exp_t;
  typedef struct {logic v0; logic [111:0] d0; logic v1; logic [111:0] d1; logic [3:0] occ0; logic [3:0] occ1;} vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vt[4];
  int   n_vec = 0, n_err = 0;
  bit   sb_en = 1'b0;

  function automatic logic [111:0] mk(input logic [31:0] src, input logic [31:0] dst,
                                      input logic [14:0] inc, input logic [14:0] burst);
    return {src, dst, 16'h0000, 1'b0, 1'b0, inc, burst};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic do_reset();
    hresetn = 1'b0; v0 = 1'b0; v1 = 1'b0; dma_done = 1'b0; clr_err = 1'b0;
    sb_q.delete();
    repeat (2) @(posedge hclk);
    #1;
    hresetn = 1'b1;
  endtask

  // Complete n transfers, each lat cycles after req is seen
  task automatic run_transfers(input int n, input int lat);
    for (int t = 0; t < n; t++) begin
      int w = 0;
      while (!dma_req && w < 60) begin
        step();
        w++;
      end
      if (!dma_req) begin
        n_vec++;
        n_err++;
        $display("FAIL req_wait: got no dma_req within 60 cycles, expected transfer %0d", t);
        return;
      end
      repeat (lat) step();
      dma_done = 1'b1;
      step();
      dma_done = 1'b0;
    end
    repeat (3) step();
  endtask

  // Scoreboard: every done pulse on the main instance must match the next expected completion
  always @(negedge hclk) begin
    if (sb_en && (r0_done || r1_done)) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got done r0=%0b r1=%0b, expected no done", r0_done, r1_done);
      end else begin
        mon_e = sb_q.pop_front();
        if ((r0_done && r1_done) || (r1_done !== mon_e.owner) ||
            ((mon_e.owner ? r1_err : r0_err) !== mon_e.err) || (src_addr !== mon_e.src)) begin
          n_err++;
          $display("FAIL sb_done: got owner=%0b err=%0b src=%0h, expected owner=%0b err=%0b src=%0h",
                   r1_done, (r1_done ? r1_err : r0_err), src_addr, mon_e.owner, mon_e.err, mon_e.src);
        end
      end
    end
  end

  initial begin
    do_reset();
    chk("rst_status", status, 32'h0000_0004);
    chk("rst_ready0", r0_ready, 1'b1);
    chk("rst_ready1", r1_ready, 1'b1);
    chk("rst_req", dma_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", {r0_done, r1_done, r0_err, r1_err}, 4'h0);
    chk("rst_fields", {src_addr, dst_addr, burst_size}, 79'd0);
    chk("rst_t_status", t_status, 32'h0000_0004);

    // Single r0 descriptor: req at cycle 3, done at 20, pulse at 21
    sb_en = 1'b1;
    v0 = 1'b1; d0 = mk(32'h1000, 32'h2000, 15'h10, 15'h40);
    sb_q.push_back('{1'b0, 1'b0, 32'h1000});
    step(); v0 = 1'b0;
    chk("s_req_c1", dma_req, 1'b0);
    chk("s_occ0_c1", status[15:12], 4'd1);
    step();
    chk("s_req_c2", dma_req, 1'b0);
    chk("s_state_c2", status[1:0], 2'd1);
    step();
    chk("s_req_c3", dma_req, 1'b1);
    chk("s_fields_c3", {src_addr, dst_addr, addr_inc, burst_size}, {32'h1000, 32'h2000, 15'h10, 15'h40});
    repeat (17) step();
    chk("s_req_c20", dma_req, 1'b1);
    dma_done = 1'b1;
    step(); dma_done = 1'b0;
    chk("s_done_c21", {r0_done, r0_err, dma_req}, 3'b100);
    chk("s_fields_c21", {src_addr, burst_size}, {32'h1000, 15'h40});
    step();
    chk("s_count", status[31:16], 16'd1);
    chk("s_state_idle", status[1:0], 2'd0);

    // Round-robin: three descriptors into each FIFO in the same cycles
    do_reset();
    for (int k = 0; k < 3; k++) begin
      vt[k] = '{1'b1, mk(32'hA000 + 32'(k), 32'h0, 15'h1, 15'h20), 1'b1, mk(32'hB000 + 32'(k), 32'h0, 15'h1, 15'h20), 4'd0, 4'd0};
    end
    vt[3] = '{1'b0, 112'd0, 1'b0, 112'd0, 4'd2, 4'd3};
    vt[0].occ0 = 4'd1; vt[0].occ1 = 4'd1;
    vt[1].occ0 = 4'd1; vt[1].occ1 = 4'd2;
    vt[2].occ0 = 4'd2; vt[2].occ1 = 4'd3;
    for (int i = 0; i < 4; i++) begin
      v0 = vt[i].v0; d0 = vt[i].d0; v1 = vt[i].v1; d1 = vt[i].d1;
      if (vt[i].v0) sb_q.push_back('{1'b0, 1'b0, vt[i].d0[111:80]});
      if (vt[i].v1) sb_q.push_back('{1'b1, 1'b0, vt[i].d1[111:80]});
      step();
      v0 = 1'b0; v1 = 1'b0;
      chk($sformatf("rr_occ0_%0d", i), status[15:12], vt[i].occ0);
      chk($sformatf("rr_occ1_%0d", i), status[11:8], vt[i].occ1);
    end
    run_transfers(6, 2);
    chk("rr_sb_empty", sb_q.size(), 0);
    chk("rr_count", status[31:16], 16'd6);

    // Fill r1 to DEPTH; a push in the pop cycle is blocked
    do_reset();
    v1 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      d1 = mk(32'hC100 + 32'(k), 32'h0, 15'h1, 15'h30);
      sb_q.push_back('{1'b1, 1'b0, 32'hC100 + 32'(k)});
      step();
    end
    v1 = 1'b0;
    chk("f_occ1_full", status[11:8], 4'd4);
    chk("f_ready1_full", r1_ready, 1'b0);
    dma_done = 1'b1;
    step(); dma_done = 1'b0;
    step();
    chk("f_state_pop", status[1:0], 2'd0);
    chk("f_ready1_pop", r1_ready, 1'b0);
    v1 = 1'b1; d1 = mk(32'hDEAD, 32'h0, 15'h1, 15'h30);
    step(); v1 = 1'b0;
    chk("f_occ1_after", status[11:8], 4'd3);
    chk("f_ready1_after", r1_ready, 1'b1);
    run_transfers(4, 1);
    chk("f_sb_empty", sb_q.size(), 0);
    chk("f_count", status[31:16], 16'd5);

    // Rejected descriptor (burst 0x0F) then smallest accepted burst (0x10)
    do_reset();
    v0 = 1'b1; d0 = mk(32'hC000, 32'hD000, 15'h1, 15'h000F);
    sb_q.push_back('{1'b0, 1'b1, 32'hC000});
    step(); v0 = 1'b0;
    chk("rj_req_c1", {dma_req, r0_done}, 2'b00);
    step();
    chk("rj_done_c2", {dma_req, r0_done, r0_err}, 3'b011);
    chk("rj_state_c2", status[1:0], 2'd3);
    step();
    chk("rj_req_c3", dma_req, 1'b0);
    chk("rj_count", status[31:16], 16'd1);
    v1 = 1'b1; d1 = mk(32'hE000, 32'h0, 15'h1, 15'h0010);
    sb_q.push_back('{1'b1, 1'b0, 32'hE000});
    step(); v1 = 1'b0;
    run_transfers(1, 0);
    chk("rj_sb_empty", sb_q.size(), 0);

    // Timeout on the TIMEOUT=8 instance: req high cycles 3..11, err pulse at 12
    sb_en = 1'b0;
    do_reset();
    v0 = 1'b1; d0 = mk(32'hF000, 32'h0, 15'h1, 15'h40);
    step(); v0 = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      chk($sformatf("to_req_c%0d", c), t_dma_req, (c >= 3 && c <= 11));
      chk($sformatf("to_done_c%0d", c), {t_r0_done, t_r0_err}, {2{c == 12}});
      step();
    end
    chk("to_sticky", t_status[3], 1'b1);
    chk("to_count", t_status[31:16], 16'd1);
    clr_err = 1'b1;
    step(); clr_err = 1'b0;
    chk("to_sticky_clr", t_status[3], 1'b0);

    // Asynchronous reset during WAIT with two descriptors queued
    do_reset();
    sb_en = 1'b1;
    v0 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      d0 = mk(32'h5000 + 32'(k), 32'h0, 15'h1, 15'h40);
      step();
    end
    v0 = 1'b0;
    step();
    chk("ar_req_pre", dma_req, 1'b1);
    chk("ar_occ0_pre", status[15:12], 4'd2);
    #2 hresetn = 1'b0;
    #1;
    chk("ar_req_now", dma_req, 1'b0);
    chk("ar_occ0_now", status[15:12], 4'd0);
    chk("ar_ready0_now", r0_ready, 1'b1);
    repeat (3) step();
    hresetn = 1'b1;
    repeat (2) step();
    chk("ar_status_post", status, 32'h0000_0004);
    chk("ar_ready_post", {r0_ready, r1_ready, dma_req, busy}, 4'b1100);

    sb_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
